rldram_cmd_gen: RTL and testbench



---
 rtl/rldram_cmd_pkg.sv | 34 +++
 rtl/rldram_bank_timer.sv | 52 +++++
 rtl/rldram_cmd_gen.sv | 234 +++++++++++++++++++++++
 tb/tb_rldram_cmd_gen.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rldram_cmd_pkg.sv
// Shared types for the RLDRAM3 command generator:
// command enum, pin encoding helper and init/run FSM states.
package rldram_cmd_pkg;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_READ,
        CMD_WRITE,
        CMD_AREF,
        CMD_MRS
    } cmd_e;

    typedef enum logic [1:0] {
        ST_INIT_WAIT,
        ST_MRS,
        ST_MRS_GAP,
        ST_RUN
    } state_e;

    // {cs_n, we_n, ref_n}
    function automatic logic [2:0] cmd_pins(cmd_e c);
        logic [2:0] p;
        p = 3'b111;
        case (c)
            CMD_READ:  p = 3'b011;
            CMD_WRITE: p = 3'b001;
            CMD_AREF:  p = 3'b010;
            CMD_MRS:   p = 3'b000;
            default:   p = 3'b111;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/rldram_bank_timer.sv
// Per-bank tRC countdown timers; a bank is free when its timer is zero.
module rldram_bank_timer
    import rldram_cmd_pkg::*;
#(
    parameter int NB_BANKS = 16,
    parameter int T_RC     = 8,
    localparam int BA_WIDTH = $clog2(NB_BANKS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [BA_WIDTH-1:0] load_ba,
    output logic [NB_BANKS-1:0] free
);

    localparam int TW = $clog2(T_RC);
    localparam logic [TW-1:0] TLOAD = TW'(T_RC - 1);

    logic [TW-1:0] tmr_q [NB_BANKS];
    logic [TW-1:0] tmr_d [NB_BANKS];

    always_comb begin
        for (int i = 0; i < NB_BANKS; i++) begin
            tmr_d[i] = tmr_q[i];
            if (load && load_ba == BA_WIDTH'(i)) begin
                tmr_d[i] = TLOAD;
            end else if (tmr_q[i] != '0) begin
                tmr_d[i] = tmr_q[i] - TW'(1);
            end
        end
    end

    // Kept apart from tmr_d so load (which depends on free) forms no loop.
    always_comb begin
        for (int i = 0; i < NB_BANKS; i++) begin
            free[i] = (tmr_q[i] == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NB_BANKS; i++) begin
                tmr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB_BANKS; i++) begin
                tmr_q[i] <= tmr_d[i];
            end
        end
    end

endmodule

// File: rtl/rldram_cmd_gen.sv
// RLDRAM3 command generator: MRS init, tRC-gated read/write, round-robin AREF.
// Define RLDRAM_CMD_PAR_EN to generate registered even parity on par_in.
module rldram_cmd_gen
    import rldram_cmd_pkg::*;
#(
    parameter int NB_BANKS     = 16,
    parameter int ADDR_WIDTH   = 20,
    parameter int T_RC         = 8,
    parameter int T_MRSC       = 4,
    parameter int INIT_CYCLES  = 200,
    parameter int REF_INTERVAL = 1024,
    parameter logic [ADDR_WIDTH-1:0] MR0_VAL = '0,
    parameter logic [ADDR_WIDTH-1:0] MR1_VAL = '0,
    parameter logic [ADDR_WIDTH-1:0] MR2_VAL = '0,
    localparam int BA_WIDTH = $clog2(NB_BANKS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [BA_WIDTH-1:0]   req_ba,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  cs_n,
    output logic                  we_n,
    output logic                  ref_n,
    output logic [BA_WIDTH-1:0]   ba,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  par_in,
    output logic                  init_done,
    output logic                  rd_issued,
    output logic                  wr_issued,
    output logic                  ref_overrun
);

    localparam int IW = $clog2(INIT_CYCLES + 1);
    localparam int GW = $clog2(T_MRSC + 1);
    localparam int RW = $clog2(REF_INTERVAL);

    state_e                state_q, state_d;
    logic [IW-1:0]         init_cnt_q, init_cnt_d;
    logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
    logic [1:0]            mrs_idx_q, mrs_idx_d;
    logic [RW-1:0]         ref_cnt_q, ref_cnt_d;
    logic                  ref_pending_q, ref_pending_d;
    logic [BA_WIDTH-1:0]   ref_ptr_q, ref_ptr_d;
    logic                  ref_overrun_q, ref_overrun_d;
    logic                  init_done_q, init_done_d;
    logic [2:0]            pins_q, pins_d;
    logic [BA_WIDTH-1:0]   ba_q, ba_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;

    cmd_e                  cmd;
    logic                  run;
    logic                  accept;
    logic                  do_ref;
    logic                  tmr_load;
    logic [BA_WIDTH-1:0]   tmr_ba;
    logic [NB_BANKS-1:0]   bank_free;

    rldram_bank_timer #(
        .NB_BANKS (NB_BANKS),
        .T_RC     (T_RC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .load_ba (tmr_ba),
        .free    (bank_free)
    );

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        mrs_idx_d  = mrs_idx_q;
        case (state_q)
            ST_INIT_WAIT: begin
                if (init_cnt_q == IW'(INIT_CYCLES - 1)) begin
                    state_d = ST_MRS;
                end else begin
                    init_cnt_d = init_cnt_q + IW'(1);
                end
            end
            ST_MRS: begin
                gap_cnt_d = '0;
                if (mrs_idx_q == 2'd2) begin
                    state_d = ST_RUN;
                end else if (T_MRSC > 1) begin
                    state_d = ST_MRS_GAP;
                end else begin
                    mrs_idx_d = mrs_idx_q + 2'd1;
                end
            end
            ST_MRS_GAP: begin
                if (gap_cnt_q == GW'(T_MRSC - 2)) begin
                    state_d   = ST_MRS;
                    mrs_idx_d = mrs_idx_q + 2'd1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT_WAIT;
        endcase
    end

    // Arbitration: MRS during init, then refresh ahead of user requests.
    always_comb begin
        run       = (state_q == ST_RUN);
        req_ready = run && !ref_pending_q && bank_free[req_ba];
        accept    = req_valid && req_ready;
        do_ref    = run && ref_pending_q && bank_free[ref_ptr_q];
        cmd       = CMD_NOP;
        ba_d      = '0;
        addr_d    = '0;
        ref_ptr_d = ref_ptr_q;
        if (state_q == ST_MRS) begin
            cmd  = CMD_MRS;
            ba_d = BA_WIDTH'(mrs_idx_q);
            case (mrs_idx_q)
                2'd0:    addr_d = MR0_VAL;
                2'd1:    addr_d = MR1_VAL;
                default: addr_d = MR2_VAL;
            endcase
        end else if (do_ref) begin
            cmd  = CMD_AREF;
            ba_d = ref_ptr_q;
            if (ref_ptr_q == BA_WIDTH'(NB_BANKS - 1)) begin
                ref_ptr_d = '0;
            end else begin
                ref_ptr_d = ref_ptr_q + BA_WIDTH'(1);
            end
        end else if (accept) begin
            cmd    = req_we ? CMD_WRITE : CMD_READ;
            ba_d   = req_ba;
            addr_d = req_addr;
        end
        pins_d      = cmd_pins(cmd);
        rd_d        = (cmd == CMD_READ);
        wr_d        = (cmd == CMD_WRITE);
        tmr_load    = do_ref || accept;
        tmr_ba      = do_ref ? ref_ptr_q : req_ba;
        init_done_d = run;
    end

    // An expiry wins over a same-cycle clear so no interval is lost.
    always_comb begin
        ref_cnt_d     = ref_cnt_q;
        ref_pending_d = ref_pending_q;
        ref_overrun_d = ref_overrun_q;
        if (do_ref) begin
            ref_pending_d = 1'b0;
        end
        if (run) begin
            if (ref_cnt_q == RW'(REF_INTERVAL - 1)) begin
                ref_cnt_d     = '0;
                ref_pending_d = 1'b1;
                if (ref_pending_q && !do_ref) begin
                    ref_overrun_d = 1'b1;
                end
            end else begin
                ref_cnt_d = ref_cnt_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_INIT_WAIT;
            init_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            mrs_idx_q     <= '0;
            ref_cnt_q     <= '0;
            ref_pending_q <= 1'b0;
            ref_ptr_q     <= '0;
            ref_overrun_q <= 1'b0;
            init_done_q   <= 1'b0;
            pins_q        <= 3'b111;
            ba_q          <= '0;
            addr_q        <= '0;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            mrs_idx_q     <= mrs_idx_d;
            ref_cnt_q     <= ref_cnt_d;
            ref_pending_q <= ref_pending_d;
            ref_ptr_q     <= ref_ptr_d;
            ref_overrun_q <= ref_overrun_d;
            init_done_q   <= init_done_d;
            pins_q        <= pins_d;
            ba_q          <= ba_d;
            addr_q        <= addr_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
        end
    end

`ifdef RLDRAM_CMD_PAR_EN
    logic par_q, par_d;

    always_comb begin
        par_d = ^{pins_d, ba_d, addr_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign par_in = par_q;
`else
    assign par_in = 1'b0;
`endif

    assign cs_n        = pins_q[2];
    assign we_n        = pins_q[1];
    assign ref_n       = pins_q[0];
    assign ba          = ba_q;
    assign addr        = addr_q;
    assign init_done   = init_done_q;
    assign rd_issued   = rd_q;
    assign wr_issued   = wr_q;
    assign ref_overrun = ref_overrun_q;

endmodule

// File: tb/tb_rldram_cmd_gen.sv
// Scoreboard bench for rldram_cmd_gen: expected pin commands are queued
// with their cycle; a negedge monitor pops and compares each one.
module tb_rldram_cmd_gen;

    localparam logic [2:0] P_READ  = 3'b011;
    localparam logic [2:0] P_WRITE = 3'b001;
    localparam logic [2:0] P_AREF  = 3'b010;
    localparam logic [2:0] P_MRS   = 3'b000;
    localparam logic [19:0] MR0 = 20'h0A031;
    localparam logic [19:0] MR1 = 20'h1B042;
    localparam logic [19:0] MR2 = 20'h2C053;

    typedef struct {
        logic [2:0]  pins;
        logic [3:0]  ba;
        logic [19:0] addr;
        int          cyc;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] got;
        logic [31:0] want;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_ba;
    logic [19:0] req_addr;
    logic        cs_n, we_n, ref_n;
    logic [3:0]  ba;
    logic [19:0] addr;
    logic        par_in;
    logic        init_done;
    logic        rd_issued, wr_issued;
    logic        ref_overrun;

    int   cyc;
    int   applied = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    chk_t chk_q[$];
    exp_t e;
    chk_t k;
    logic exp_par;

    rldram_cmd_gen #(
        .NB_BANKS     (16),
        .ADDR_WIDTH   (20),
        .T_RC         (8),
        .T_MRSC       (4),
        .INIT_CYCLES  (200),
        .REF_INTERVAL (1024),
        .MR0_VAL      (MR0),
        .MR1_VAL      (MR1),
        .MR2_VAL      (MR2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_ba      (req_ba),
        .req_addr    (req_addr),
        .cs_n        (cs_n),
        .we_n        (we_n),
        .ref_n       (ref_n),
        .ba          (ba),
        .addr        (addr),
        .par_in      (par_in),
        .init_done   (init_done),
        .rd_issued   (rd_issued),
        .wr_issued   (wr_issued),
        .ref_overrun (ref_overrun)
    );

    always #5 clk = ~clk;

    // Edge count since reset release: pins after edge n are at cyc == n.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        while (chk_q.size() > 0) begin
            k = chk_q.pop_front();
            applied++;
            if (k.got !== k.want) begin
                miscompares++;
                $display("FAIL %s: got %0h, want %0h", k.name, k.got, k.want);
            end
        end
        if (!rst) begin
            if (!cs_n || rd_issued || wr_issued) begin
                applied++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_cmd: cyc %0d pins %b ba %0d addr %h",
                             cyc, {cs_n, we_n, ref_n}, ba, addr);
                end else begin
                    e = exp_q.pop_front();
                    if ({cs_n, we_n, ref_n} !== e.pins || ba !== e.ba ||
                        addr !== e.addr || cyc != e.cyc ||
                        rd_issued !== (e.pins == P_READ) ||
                        wr_issued !== (e.pins == P_WRITE)) begin
                        miscompares++;
                        $display("FAIL cmd: got cyc %0d pins %b ba %0d addr %h rd %b wr %b, want cyc %0d pins %b ba %0d addr %h",
                                 cyc, {cs_n, we_n, ref_n}, ba, addr, rd_issued,
                                 wr_issued, e.cyc, e.pins, e.ba, e.addr);
                    end
                end
            end
            if (cyc >= 1) begin
`ifdef RLDRAM_CMD_PAR_EN
                exp_par = ^{cs_n, we_n, ref_n, ba, addr};
`else
                exp_par = 1'b0;
`endif
                applied++;
                if (par_in !== exp_par) begin
                    miscompares++;
                    $display("FAIL parity: cyc %0d got %b, want %b", cyc, par_in, exp_par);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        chk_t c;
        c.name = nm;
        c.got  = got;
        c.want = want;
        chk_q.push_back(c);
    endtask

    task automatic expect_cmd(input logic [2:0] p, input logic [3:0] b,
                              input logic [19:0] a, input int c);
        exp_t x;
        x.pins = p;
        x.ba   = b;
        x.addr = a;
        x.cyc  = c;
        exp_q.push_back(x);
    endtask

    task automatic at_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds the request until accepted; checks the stall count.
    task automatic send(input logic we, input logic [3:0] b, input logic [19:0] a,
                        input int want_stalls, input string nm);
        int st;
        st = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_ba    = b;
        req_addr  = a;
        forever begin
            @(negedge clk);
            if (req_ready || st >= 200) break;
            st++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check(nm, 32'(st), 32'(want_stalls));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_ba    = 4'd0;
        req_addr  = 20'd0;
        repeat (3) @(posedge clk);
        #1;
        req_valid = 1'b1;
        #1;
        check("rst_pins", 32'({cs_n, we_n, ref_n}), 32'h7);
        check("rst_ba_addr", 32'({ba, addr}), 32'h0);
        check("rst_flags", 32'({par_in, init_done, rd_issued, wr_issued,
                               ref_overrun, req_ready}), 32'h0);
        req_valid = 1'b0;

        expect_cmd(P_MRS, 4'd0, MR0, 201);
        expect_cmd(P_MRS, 4'd1, MR1, 205);
        expect_cmd(P_MRS, 4'd2, MR2, 209);
        @(negedge clk);
        rst = 1'b0;

        at_cyc(100);
        req_valid = 1'b1;
        #1;
        check("init_ready", 32'(req_ready), 32'h0);
        req_valid = 1'b0;
        at_cyc(209);
        check("init_done_209", 32'(init_done), 32'h0);
        at_cyc(210);
        check("init_done_210", 32'(init_done), 32'h1);

        // Same-bank reads: tRC spacing
        at_cyc(300);
        expect_cmd(P_READ, 4'd3, 20'h11111, 301);
        send(1'b0, 4'd3, 20'h11111, 0, "b3_rd0_stall");
        expect_cmd(P_READ, 4'd3, 20'h22222, 309);
        send(1'b0, 4'd3, 20'h22222, 7, "b3_rd1_stall");
        expect_cmd(P_READ, 4'd3, 20'h33333, 317);
        send(1'b0, 4'd3, 20'h33333, 7, "b3_rd2_stall");

        // Interleaved banks back to back
        at_cyc(400);
        for (int i = 0; i < 4; i++) begin
            expect_cmd(P_WRITE, 4'(i), 20'hA0000 + 20'(i), 401 + i);
        end
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 4'(i), 20'hA0000 + 20'(i), 0, "wr_ilv_stall");
        end

        // Refresh, and a request in the expiry cycle still accepted
        expect_cmd(P_AREF, 4'd0, 20'h0, 1234);
        expect_cmd(P_WRITE, 4'd9, 20'h99999, 2257);
        expect_cmd(P_AREF, 4'd1, 20'h0, 2258);
        at_cyc(2256);
        send(1'b1, 4'd9, 20'h99999, 0, "expiry_req_stall");
        for (int r = 2; r < 5; r++) begin
            expect_cmd(P_AREF, 4'(r), 20'h0, 1234 + 1024 * r);
        end

        // Refresh to a busy bank waits for its timer and blocks requests
        expect_cmd(P_READ, 4'd5, 20'h55501, 6341);
        expect_cmd(P_READ, 4'd5, 20'h55502, 6349);
        expect_cmd(P_AREF, 4'd5, 20'h0, 6357);
        expect_cmd(P_READ, 4'd5, 20'h55503, 6365);
        at_cyc(6340);
        send(1'b0, 4'd5, 20'h55501, 0, "b5_rd0_stall");
        send(1'b0, 4'd5, 20'h55502, 7, "b5_rd1_stall");
        send(1'b0, 4'd5, 20'h55503, 15, "b5_rd2_stall");

        // Remaining refreshes including the wrap back to bank 0
        for (int r = 6; r < 17; r++) begin
            expect_cmd(P_AREF, 4'(r % 16), 20'h0, 1234 + 1024 * r);
        end

        // Reset while a WRITE is on the pins
        at_cyc(17700);
        check("overrun", 32'(ref_overrun), 32'h0);
        expect_cmd(P_WRITE, 4'd7, 20'h7ABCD, 17701);
        send(1'b1, 4'd7, 20'h7ABCD, 0, "b7_wr_stall");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_pins", 32'({cs_n, we_n, ref_n, wr_issued}), 32'hE);
        check("midrst_ba_addr", 32'({ba, addr}), 32'h0);
        expect_cmd(P_MRS, 4'd0, MR0, 201);
        expect_cmd(P_MRS, 4'd1, MR1, 205);
        expect_cmd(P_MRS, 4'd2, MR2, 209);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        at_cyc(209);
        check("reinit_done_209", 32'(init_done), 32'h0);
        at_cyc(215);
        check("reinit_done", 32'(init_done), 32'h1);
        check("queue_drain", 32'(exp_q.size()), 32'h0);

        repeat (2) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
